// File: rtl/rs_pkg.sv
// Shared serial-link definitions: bit-rate select codes, select-to-period
// mapping for the 25 MHz clock, and the receiver FSM state encoding.
package rs_pkg;

   localparam logic [3:0] RS_SEL_1200   = 4'h0;
   localparam logic [3:0] RS_SEL_2400   = 4'h1;
   localparam logic [3:0] RS_SEL_4800   = 4'h2;
   localparam logic [3:0] RS_SEL_9600   = 4'h3;
   localparam logic [3:0] RS_SEL_19200  = 4'h4;
   localparam logic [3:0] RS_SEL_38400  = 4'h5;
   localparam logic [3:0] RS_SEL_57600  = 4'h6;
   localparam logic [3:0] RS_SEL_115200 = 4'h7;
   localparam logic [3:0] RS_SEL_230400 = 4'h8;
   localparam logic [3:0] RS_SEL_460800 = 4'h9;
   localparam logic [3:0] RS_SEL_921600 = 4'hA;

   localparam int RS_CNT_W = 15;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
`ifdef RSRX_PARITY_EN
      RX_PARITY = 3'd3,
`endif
      RX_STOP   = 3'd4,
      RX_BREAK  = 3'd5
   } rx_state_e;

   // Unlisted select codes fall back to 9600 bps.
   function automatic logic [RS_CNT_W-1:0] bit_period(input logic [3:0] sel);
      case (sel)
         RS_SEL_1200:   bit_period = 15'd20833;
         RS_SEL_2400:   bit_period = 15'd10416;
         RS_SEL_4800:   bit_period = 15'd5208;
         RS_SEL_9600:   bit_period = 15'd2604;
         RS_SEL_19200:  bit_period = 15'd1302;
         RS_SEL_38400:  bit_period = 15'd651;
         RS_SEL_57600:  bit_period = 15'd434;
         RS_SEL_115200: bit_period = 15'd217;
         RS_SEL_230400: bit_period = 15'd108;
         RS_SEL_460800: bit_period = 15'd54;
         RS_SEL_921600: bit_period = 15'd27;
         default:       bit_period = 15'd2604;
      endcase
   endfunction

endpackage

// File: rtl/rs_sync2.sv
// Two-flop synchronizer for an idle-high asynchronous input; both flops
// reset to 1 so a reset never looks like a falling edge.
module rs_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/rs_rx_byte.sv
// UART byte receiver (8N1, or 8E1 when RSRX_PARITY_EN is defined); bit timing
// is re-anchored on every start edge. rx_state exposes the FSM state.
module rs_rx_byte
   import rs_pkg::*;
(
   input  logic       F25Clk,
   input  logic       reset_n,
   input  logic       RxD,
   input  logic [3:0] BitRateSel,
   output logic [7:0] RxData,
   output logic       RxValid,
   output logic       FrameErr,
   output logic       ParityErr,
   output logic       RxBusy,
   output rx_state_e  rx_state
);

   logic                rxs;
   logic                rxs_q;
   logic [3:0]          sel_q;
   logic [RS_CNT_W-1:0] period;
   logic [RS_CNT_W-1:0] cnt;
   logic [RS_CNT_W-1:0] target;
   logic [2:0]          bit_idx;
   logic [7:0]          shreg;
   logic                expiry;
   logic                cnt_clr;
   logic                latch_rate;
   logic                shift_en;
   logic                frame_done;
   rx_state_e           state;
   rx_state_e           state_nx;
`ifdef RSRX_PARITY_EN
   logic                par_bit;
   logic                par_load;
`endif

   rs_sync2 u_sync_rxd (
      .clk   (F25Clk),
      .rst_n (reset_n),
      .d     (RxD),
      .q     (rxs)
   );

   assign rx_state = state;
   assign target   = (state == RX_START) ? (period >> 1) : period;
   assign expiry   = (cnt == target - 15'd1);

   always_comb begin
      state_nx   = state;
      latch_rate = 1'b0;
      shift_en   = 1'b0;
      frame_done = 1'b0;
`ifdef RSRX_PARITY_EN
      par_load   = 1'b0;
`endif
      case (state)
         RX_IDLE: begin
            if (rxs_q && !rxs) begin
               state_nx   = RX_START;
               latch_rate = 1'b1;
            end
         end
         RX_START: begin
            if (expiry) state_nx = rxs ? RX_IDLE : RX_DATA;
         end
         RX_DATA: begin
            if (expiry) begin
               shift_en = 1'b1;
               if (bit_idx == 3'd7) begin
`ifdef RSRX_PARITY_EN
                  state_nx = RX_PARITY;
`else
                  state_nx = RX_STOP;
`endif
               end
            end
         end
`ifdef RSRX_PARITY_EN
         RX_PARITY: begin
            if (expiry) begin
               par_load = 1'b1;
               state_nx = RX_STOP;
            end
         end
`endif
         RX_STOP: begin
            // Returning to IDLE mid-stop-bit lets a back-to-back start edge be seen.
            if (expiry) begin
               frame_done = 1'b1;
               state_nx   = rxs ? RX_IDLE : RX_BREAK;
            end
         end
         RX_BREAK: begin
            if (rxs) state_nx = RX_IDLE;
         end
         default: state_nx = RX_IDLE;
      endcase
   end

   assign cnt_clr = (state_nx != state) || expiry || (state == RX_IDLE);

   always_ff @(posedge F25Clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= RX_IDLE;
         rxs_q   <= 1'b1;
         sel_q   <= 4'h0;
         period  <= 15'd2604;
         cnt     <= '0;
         bit_idx <= 3'd0;
         shreg   <= 8'h00;
      end else begin
         state <= state_nx;
         rxs_q <= rxs;
         sel_q <= BitRateSel;
         cnt   <= cnt_clr ? '0 : cnt + 15'd1;
         if (latch_rate) period <= bit_period(sel_q);
         if (state == RX_IDLE) bit_idx <= 3'd0;
         else if (shift_en)    bit_idx <= bit_idx + 3'd1;
         if (shift_en) shreg <= {rxs, shreg[7:1]};
      end
   end

`ifdef RSRX_PARITY_EN
   always_ff @(posedge F25Clk or negedge reset_n) begin
      if (!reset_n)      par_bit <= 1'b0;
      else if (par_load) par_bit <= rxs;
   end
`endif

   always_ff @(posedge F25Clk or negedge reset_n) begin
      if (!reset_n) begin
         RxData    <= 8'h00;
         RxValid   <= 1'b0;
         FrameErr  <= 1'b0;
         ParityErr <= 1'b0;
         RxBusy    <= 1'b0;
      end else begin
         RxValid  <= frame_done;
         FrameErr <= frame_done & ~rxs;
`ifdef RSRX_PARITY_EN
         ParityErr <= frame_done & ((^shreg) ^ par_bit);
`else
         ParityErr <= 1'b0;
`endif
         if (frame_done) RxData <= shreg;
         RxBusy <= (state_nx != RX_IDLE) && (state_nx != RX_START);
      end
   end

endmodule

// File: tb/tb_rs_rx_byte.sv
// Self-checking bench for rs_rx_byte: frames are driven bit by bit and each
// strobe is compared (cycle, data, flags) against a frame-level timing model.
module tb_rs_rx_byte;
   import rs_pkg::*;

`ifdef RSRX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
   localparam int NBITS  = 10;
`else
   localparam bit PAR_EN = 1'b0;
   localparam int NBITS  = 9;
`endif

   logic       F25Clk = 1'b0;
   logic       reset_n;
   logic       RxD;
   logic [3:0] BitRateSel;
   logic [7:0] RxData;
   logic       RxValid;
   logic       FrameErr;
   logic       ParityErr;
   logic       RxBusy;
   rx_state_e  rx_state;

   int vec_cnt = 0;
   int err_cnt = 0;
   int cyc     = 0;
   int stray   = 0;
   // record: {cycle[31:0], data[7:0], frame_err, parity_err}
   logic [41:0] exp_q[$];
   logic [41:0] got_q[$];

   rs_rx_byte dut (
      .F25Clk     (F25Clk),
      .reset_n    (reset_n),
      .RxD        (RxD),
      .BitRateSel (BitRateSel),
      .RxData     (RxData),
      .RxValid    (RxValid),
      .FrameErr   (FrameErr),
      .ParityErr  (ParityErr),
      .RxBusy     (RxBusy),
      .rx_state   (rx_state)
   );

   always #20 F25Clk = ~F25Clk;

   always @(posedge F25Clk) cyc <= cyc + 1;

   always @(negedge F25Clk) begin
      if (RxValid) got_q.push_back({32'(cyc), RxData, FrameErr, ParityErr});
      if ((FrameErr || ParityErr) && !RxValid) stray++;
   end

   function automatic int p_of(input logic [3:0] sel);
      int tab [11] = '{20833, 10416, 5208, 2604, 1302, 651, 434, 217, 108, 54, 27};
      return (sel <= 4'hA) ? tab[sel] : 2604;
   endfunction

   // Must be called at a negedge. The strobe is expected 3+H+NBITS*P posedges later.
   task automatic send_frame(input logic [7:0] data, input int p, input logic par,
                             input logic stop, input bit expect_it);
      logic [31:0] t_exp;
      logic        perr;
      t_exp = 32'(cyc + 3 + (p >> 1) + NBITS * p);
      perr  = PAR_EN ? ((^data) ^ par) : 1'b0;
      if (expect_it) exp_q.push_back({t_exp, data, ~stop, perr});
      RxD = 1'b0;
      repeat (p) @(negedge F25Clk);
      for (int i = 0; i < 8; i++) begin
         RxD = data[i];
         repeat (p) @(negedge F25Clk);
      end
      if (PAR_EN) begin
         RxD = par;
         repeat (p) @(negedge F25Clk);
      end
      RxD = stop;
      repeat (p) @(negedge F25Clk);
   endtask

   task automatic test_reset;
      reset_n = 1'b0; RxD = 1'b1; BitRateSel = 4'h0;
      repeat (3) @(negedge F25Clk);
      vec_cnt++;
      if ({RxData, RxValid, FrameErr, ParityErr, RxBusy} !== 12'h000) begin
         err_cnt++;
         $display("FAIL reset_outputs: got %03h, expected 000", {RxData, RxValid, FrameErr, ParityErr, RxBusy});
      end
      vec_cnt++;
      if (rx_state !== RX_IDLE) begin
         err_cnt++;
         $display("FAIL reset_state: got %0d, expected %0d", rx_state, RX_IDLE);
      end
      reset_n = 1'b1;
      repeat (4) @(negedge F25Clk);
      vec_cnt++;
      if ({RxData, RxValid, FrameErr, ParityErr, RxBusy, rx_state} !== {12'h000, RX_IDLE}) begin
         err_cnt++;
         $display("FAIL post_reset_idle: got %03h/%0d, expected 000/0", {RxData, RxValid, FrameErr, ParityErr, RxBusy}, rx_state);
      end
   endtask

   task automatic test_single;
      logic [41:0] e, g;
      BitRateSel = 4'h3;
      repeat (4) @(negedge F25Clk);
      send_frame(8'hA5, p_of(4'h3), 1'b0, 1'b1, 1'b1);
      repeat (4) @(negedge F25Clk);
      vec_cnt++;
      if (RxBusy !== 1'b0) begin
         err_cnt++;
         $display("FAIL single_busy: got %0b, expected 0", RxBusy);
      end
      vec_cnt++;
      if (got_q.size() != exp_q.size()) begin
         err_cnt++;
         $display("FAIL single_count: got %0d strobes, expected %0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); vec_cnt++;
         if (g !== e) begin
            err_cnt++;
            $display("FAIL single_frame: got cyc=%0d data=%02h ferr=%0b perr=%0b, expected cyc=%0d data=%02h ferr=%0b perr=%0b",
                     g[41:10], g[9:2], g[1], g[0], e[41:10], e[9:2], e[1], e[0]);
         end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_back_to_back;
      logic [41:0] e, g;
      logic [7:0]  d [6];
      d[0] = 8'h00; d[1] = 8'hFF; d[2] = 8'h3C;
      for (int i = 3; i < 6; i++) d[i] = 8'($urandom);
      BitRateSel = 4'hA;
      repeat (4) @(negedge F25Clk);
      for (int i = 0; i < 6; i++) send_frame(d[i], p_of(4'hA), ^d[i], 1'b1, 1'b1);
      repeat (4) @(negedge F25Clk);
      vec_cnt++;
      if (got_q.size() != exp_q.size()) begin
         err_cnt++;
         $display("FAIL b2b_count: got %0d strobes, expected %0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); vec_cnt++;
         if (g !== e) begin
            err_cnt++;
            $display("FAIL b2b_frame: got cyc=%0d data=%02h ferr=%0b perr=%0b, expected cyc=%0d data=%02h ferr=%0b perr=%0b",
                     g[41:10], g[9:2], g[1], g[0], e[41:10], e[9:2], e[1], e[0]);
         end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_glitch;
      BitRateSel = 4'hF;
      repeat (4) @(negedge F25Clk);
      RxD = 1'b0;
      repeat (200) @(negedge F25Clk);
      vec_cnt++;
      if (rx_state !== RX_START) begin
         err_cnt++;
         $display("FAIL glitch_detect: got state %0d, expected %0d", rx_state, RX_START);
      end
      repeat (200) @(negedge F25Clk);
      RxD = 1'b1;
      repeat (1600) @(negedge F25Clk);
      vec_cnt++;
      if ({got_q.size() == 0, RxBusy, rx_state} !== {1'b1, 1'b0, RX_IDLE}) begin
         err_cnt++;
         $display("FAIL glitch_reject: got strobes=%0d busy=%0b state=%0d, expected 0/0/0", got_q.size(), RxBusy, rx_state);
      end
      got_q.delete();
   endtask

   task automatic test_break;
      logic [41:0] e, g;
      int p;
      BitRateSel = 4'h9;
      p = p_of(4'h9);
      repeat (4) @(negedge F25Clk);
      send_frame(8'h00, p, 1'b0, 1'b0, 1'b1);
      repeat (5 * p) @(negedge F25Clk);
      vec_cnt++;
      if ({RxBusy, rx_state} !== {1'b1, RX_BREAK}) begin
         err_cnt++;
         $display("FAIL break_hold: got busy=%0b state=%0d, expected 1/%0d", RxBusy, rx_state, RX_BREAK);
      end
      RxD = 1'b1;
      repeat (8) @(negedge F25Clk);
      vec_cnt++;
      if ({RxBusy, rx_state} !== {1'b0, RX_IDLE}) begin
         err_cnt++;
         $display("FAIL break_release: got busy=%0b state=%0d, expected 0/0", RxBusy, rx_state);
      end
      vec_cnt++;
      if (got_q.size() != exp_q.size()) begin
         err_cnt++;
         $display("FAIL break_count: got %0d strobes, expected %0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); vec_cnt++;
         if (g !== e) begin
            err_cnt++;
            $display("FAIL break_frame: got cyc=%0d data=%02h ferr=%0b perr=%0b, expected cyc=%0d data=%02h ferr=%0b perr=%0b",
                     g[41:10], g[9:2], g[1], g[0], e[41:10], e[9:2], e[1], e[0]);
         end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_rate_latch;
      logic [41:0] e, g;
      logic [7:0]  d;
      d = 8'($urandom);
      BitRateSel = 4'h9;
      repeat (4) @(negedge F25Clk);
      fork
         send_frame(d, p_of(4'h9), ^d, 1'b1, 1'b1);
         begin
            repeat (100) @(negedge F25Clk);
            BitRateSel = 4'h7;
         end
      join
      repeat (4) @(negedge F25Clk);
      vec_cnt++;
      if (got_q.size() != exp_q.size()) begin
         err_cnt++;
         $display("FAIL latch_count: got %0d strobes, expected %0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); vec_cnt++;
         if (g !== e) begin
            err_cnt++;
            $display("FAIL latch_frame: got cyc=%0d data=%02h ferr=%0b perr=%0b, expected cyc=%0d data=%02h ferr=%0b perr=%0b",
                     g[41:10], g[9:2], g[1], g[0], e[41:10], e[9:2], e[1], e[0]);
         end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_reset_abort;
      logic [41:0] e, g;
      int p;
      BitRateSel = 4'h8;
      p = p_of(4'h8);
      repeat (4) @(negedge F25Clk);
      // All-ones payload keeps the line high after the start bit, so no new edge follows the abort.
      fork
         send_frame(8'hFF, p, 1'b0, 1'b1, 1'b0);
         begin
            repeat (3 * p) @(negedge F25Clk);
            vec_cnt++;
            if ({RxBusy, rx_state} !== {1'b1, RX_DATA}) begin
               err_cnt++;
               $display("FAIL abort_pre: got busy=%0b state=%0d, expected 1/%0d", RxBusy, rx_state, RX_DATA);
            end
            reset_n = 1'b0;
            repeat (2) @(negedge F25Clk);
            vec_cnt++;
            if ({RxBusy, RxValid, rx_state} !== {1'b0, 1'b0, RX_IDLE}) begin
               err_cnt++;
               $display("FAIL abort_reset: got busy=%0b valid=%0b state=%0d, expected 0/0/0", RxBusy, RxValid, rx_state);
            end
            reset_n = 1'b1;
         end
      join
      repeat (p) @(negedge F25Clk);
      vec_cnt++;
      if (got_q.size() != 0) begin
         err_cnt++;
         $display("FAIL abort_nostrobe: got %0d strobes, expected 0", got_q.size());
      end
      got_q.delete();
      send_frame(8'h55, p, 1'b0, 1'b1, 1'b1);
      repeat (4) @(negedge F25Clk);
      vec_cnt++;
      if (got_q.size() != exp_q.size()) begin
         err_cnt++;
         $display("FAIL abort_next_count: got %0d strobes, expected %0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); vec_cnt++;
         if (g !== e) begin
            err_cnt++;
            $display("FAIL abort_next_frame: got cyc=%0d data=%02h ferr=%0b perr=%0b, expected cyc=%0d data=%02h ferr=%0b perr=%0b",
                     g[41:10], g[9:2], g[1], g[0], e[41:10], e[9:2], e[1], e[0]);
         end
      end
      exp_q.delete(); got_q.delete();
   endtask

`ifdef RSRX_PARITY_EN
   task automatic test_parity;
      logic [41:0] e, g;
      BitRateSel = 4'hA;
      repeat (4) @(negedge F25Clk);
      send_frame(8'h07, p_of(4'hA), 1'b1, 1'b1, 1'b1);
      send_frame(8'h07, p_of(4'hA), 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) send_frame(8'($urandom), p_of(4'hA), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
      repeat (4) @(negedge F25Clk);
      vec_cnt++;
      if (got_q.size() != exp_q.size()) begin
         err_cnt++;
         $display("FAIL parity_count: got %0d strobes, expected %0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); vec_cnt++;
         if (g !== e) begin
            err_cnt++;
            $display("FAIL parity_frame: got cyc=%0d data=%02h ferr=%0b perr=%0b, expected cyc=%0d data=%02h ferr=%0b perr=%0b",
                     g[41:10], g[9:2], g[1], g[0], e[41:10], e[9:2], e[1], e[0]);
         end
      end
      exp_q.delete(); got_q.delete();
   endtask
`endif

   task automatic test_random;
      logic [41:0] e, g;
      logic [3:0]  sel;
      int          p;
      for (int n = 0; n < 8; n++) begin
         sel = 4'($urandom_range(7, 10));
         p   = p_of(sel);
         BitRateSel = sel;
         repeat (3) @(negedge F25Clk);
         send_frame(8'($urandom), p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'b1);
         RxD = 1'b1;
         repeat ($urandom_range(2, 2 * p)) @(negedge F25Clk);
      end
      repeat (4) @(negedge F25Clk);
      vec_cnt++;
      if (got_q.size() != exp_q.size()) begin
         err_cnt++;
         $display("FAIL random_count: got %0d strobes, expected %0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); vec_cnt++;
         if (g !== e) begin
            err_cnt++;
            $display("FAIL random_frame: got cyc=%0d data=%02h ferr=%0b perr=%0b, expected cyc=%0d data=%02h ferr=%0b perr=%0b",
                     g[41:10], g[9:2], g[1], g[0], e[41:10], e[9:2], e[1], e[0]);
         end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_default_rate;
      logic [41:0] e, g;
      logic [7:0]  d;
      d = 8'($urandom);
      BitRateSel = 4'hC;
      repeat (4) @(negedge F25Clk);
      send_frame(d, p_of(4'hC), ^d, 1'b1, 1'b1);
      repeat (4) @(negedge F25Clk);
      vec_cnt++;
      if (got_q.size() != exp_q.size()) begin
         err_cnt++;
         $display("FAIL default_count: got %0d strobes, expected %0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); vec_cnt++;
         if (g !== e) begin
            err_cnt++;
            $display("FAIL default_frame: got cyc=%0d data=%02h ferr=%0b perr=%0b, expected cyc=%0d data=%02h ferr=%0b perr=%0b",
                     g[41:10], g[9:2], g[1], g[0], e[41:10], e[9:2], e[1], e[0]);
         end
      end
      exp_q.delete(); got_q.delete();
   endtask

   initial begin
      reset_n    = 1'b0;
      RxD        = 1'b1;
      BitRateSel = 4'h0;
      test_reset;
      test_single;
      test_back_to_back;
      test_glitch;
      test_break;
      test_rate_latch;
      test_reset_abort;
`ifdef RSRX_PARITY_EN
      test_parity;
`endif
      test_random;
      test_default_rate;
      vec_cnt++;
      if (stray != 0) begin
         err_cnt++;
         $display("FAIL stray_flags: got %0d error strobes without RxValid, expected 0", stray);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/rs_rx_byte.md
# rs_rx_byte

UART byte receiver: the receive end of the serial link whose transmit side is clocked by the shared bit-rate clock generator. It samples the asynchronous RxD line in the F25Clk (25 MHz) domain and recovers the bit timing from each start edge with a local period counter, using the same BitRateSel encoding as the transmit side. It delivers one 8N1 byte per frame as a single-cycle valid strobe, with framing and optional parity error flags. The block sits between the board RxD pin and the command/FIFO logic.

## Interface
- No parameters. The bit-rate table is fixed; see Structure.
- F25Clk  in  1  system clock, 25 MHz. Single clock domain.
- reset_n  in  1  asynchronous active-low reset.
- RxD  in  1  serial input, asynchronous, idle high.
- BitRateSel  in  4  rate select, same encoding as the transmit side. Values 0..A select 1200..921600 bps; other values select 9600.
- RxData  out  8  last received byte, LSB received first.
- RxValid  out  1  one-cycle strobe: RxData updated.
- FrameErr  out  1  one-cycle strobe, coincident with RxValid: stop bit sampled 0.
- ParityErr  out  1  one-cycle strobe, coincident with RxValid: even-parity mismatch. Constant 0 without RSRX_PARITY_EN.
- RxBusy  out  1  high from the confirmed start bit until the frame is released.

## Operation
- RxD passes through a 2-flop synchronizer. The block acts on the synchronized value rxs only.
- Bit period P in clocks: 20833, 10416, 5208, 2604, 1302, 651, 434, 217, 108, 54, 27 for sel 0..A; 2604 for other values. H = P>>1.
- BitRateSel is registered every cycle. Its value is latched into the frame rate register only on leaving IDLE, so a change mid-frame has no effect until the next frame.
- Counter cnt is 15 bits and is cleared on every state entry. An expiry event fires when cnt == target-1.
- FSM states and transitions:
  - IDLE: a falling edge on rxs (prev 1, now 0) → START.
  - START: at expiry of H, sample rxs. If 0 → DATA with bit index 0 and RxBusy=1. If 1 (glitch) → IDLE with no outputs.
  - DATA: at each expiry of P, shift rxs in at bit 7 (LSB first). After the 8th sample → PARITY if enabled, else → STOP.
  - PARITY: at expiry of P, sample the parity bit → STOP.
  - STOP: at expiry of P, sample the stop bit. Load RxData and pulse RxValid, plus FrameErr if the stop sample is 0 and ParityErr on mismatch. If the stop sample is 1 → IDLE. If 0 → BREAK.
  - BREAK: wait until rxs == 1 → IDLE. This prevents a break condition from being decoded as 0x00 frames. RxBusy stays 1.
- RxData holds its value between frames and is overwritten even on an errored frame.
- Reset asserted mid-frame aborts the frame immediately: state IDLE, all outputs at reset values, no strobe.

## Timing
- Reset values: RxData=8'h00, RxValid=0, FrameErr=0, ParityErr=0, RxBusy=0, state IDLE, both synchronizer flops 1.
- Take the pin falling edge at cycle 0. rxs falls at cycle 2. The start mid-sample is at 2+H.
- Data bit k is sampled at 2+H+(k+1)·P. The stop bit is sampled at 2+H+9·P, or 2+H+10·P with parity enabled.
- Strobes are registered, asserted in the cycle after the stop sample, and last exactly one cycle. RxBusy falls in that same cycle when the stop bit is 1.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so the next start edge half a bit later is detected. No gap is required.
- No fractional-period accumulation is performed: the start edge re-anchors every frame. Worst-case drift at 921600 bps is about 0.5%/bit, under 5% at the stop bit.

## Configuration
- RSRX_PARITY_EN defined:
  - Frame is start, 8 data bits, even-parity bit, stop.
  - PARITY state is present.
  - ParityErr = (^RxData) ^ parity sample.
- RSRX_PARITY_EN undefined:
  - Frame is 8N1 and the PARITY state is absent.
  - ParityErr is tied 0.

## Structure
- Shared package rs_pkg:
  - the BitRateSel-to-P function, with the default case;
  - the FSM state encoding;
  - the bit-rate select constants, also used by the transmit-side generator.
- One sub-module, rs_sync2: 2-flop synchronizer with reset value 1. It is instantiated for RxD.

## Test plan
- BitRateSel=3, send 0xA5 8N1 → RxValid one cycle at 2+1302+9·2604+1 cycles after the start edge, RxData=0xA5, FrameErr=0.
- BitRateSel=A, send 0x00, 0xFF, 0x3C back-to-back with no idle → three RxValid strobes with the correct data in order, no errors.
- A 400-cycle low glitch at 9600 → no RxValid, RxBusy returns to 0, state IDLE.
- Stop bit driven 0, then the line held low for 5 bit times → one RxValid with FrameErr=1, RxData=0x00, no further strobes until the line returns high.
- With RSRX_PARITY_EN: 0x07 with parity 1 → ParityErr=0; with parity 0 → ParityErr=1.
- reset_n pulsed low mid-DATA, then a clean 0x55 frame → the aborted frame produces no strobe, and the next frame gives RxData=0x55.
